gf26_mul_array_arbiter: RTL and testbench
=========================================

Name: gf26_mul_array_arbiter

Overview:
- Shares one gf26_mul_array instance (54-bit x operand, 48-bit y operand, 54-bit result) between NUM_REQ GF(2^6) decoder stages: key-equation solver, error evaluator and Forney stage.
- Captures single-cycle start pulses and operands, then serves requests round-robin.
- Sequences the multiplier start/flag handshake and returns the result with a one-cycle done pulse to the granted requester.
- Includes a watchdog so a hung multiplier cannot stall the decoder.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- TIMEOUT_CYC, 255, maximum WAIT cycles before abort (1..255).

Ports:
- clk  in  1  clock.
- resetN  in  1  synchronous, active-low reset.
- req_start  in  NUM_REQ  per-requester start pulse.
- req_x  in  NUM_REQ*54  packed x operands; requester i occupies bits [i*54+:54].
- req_y  in  NUM_REQ*48  packed y operands; requester i occupies bits [i*48+:48].
- req_done  out  NUM_REQ  one-hot, one-cycle completion pulse.
- req_res  out  54  result of the last completed job.
- busy  out  1  high when any request is pending or state != IDLE.
- protocol_err  out  1  sticky: a start arrived while that requester already had a request pending.
- timeout_err  out  1  sticky: the watchdog expired.
- mul_start  out  1  start pulse to gf26_mul_array.
- mul_x  out  54  x operand to the multiplier.
- mul_y  out  48  y operand to the multiplier.
- mul_flag  in  1  multiplier completion flag.
- mul_res  in  54  multiplier result.

Behaviour:
- Reset, sampled at a clk edge with resetN=0:
  - state=IDLE; pending, req_done, mul_start, busy, both error flags, req_res and operand buffers all 0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
- Request capture:
  - req_start[i]=1 with pending[i]=0: set pending[i] and latch req_x/req_y slice i into buffer i at that edge.
  - req_start[i]=1 with pending[i]=1 (queued or in service): ignored, buffer unchanged, protocol_err set.
  - Exception: a start from the granted requester during its DELIVER cycle is accepted. The new capture wins over the clear.
- mul_x and mul_y are always driven from buffer[grant]. Operands are therefore stable from ISSUE through WAIT.
- FSM IDLE:
  - If any pending bit is set, grant = first pending index searching upward from last_grant+1, modulo NUM_REQ. Then go to ISSUE.
  - Otherwise stay in IDLE.
- FSM ISSUE: mul_start=1 for exactly this cycle; clear the watchdog counter; go to WAIT.
- FSM WAIT:
  - mul_flag=1: latch mul_res into req_res; go to DELIVER.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYC: set timeout_err, set req_res=0, go to DELIVER.
  - mul_flag in any other state is ignored.
- FSM DELIVER:
  - req_done[grant]=1 for this cycle only; req_res is valid in this cycle.
  - Clear pending[grant]; last_grant=grant; go to IDLE.
- req_res holds its value until the next DELIVER.
- Latency:
  - req_start sampled at edge T: pending visible in cycle T+1 (IDLE), mul_start high in cycle T+2, WAIT from T+3.
  - mul_flag sampled at edge E: req_done high in the cycle following E.
  - Minimum start-to-done is 4 cycles plus the multiplier latency.
- Simultaneous starts from several requesters: all are captured in the same cycle and served in round-robin order. There are no gaps beyond the IDLE cycle between jobs.
- Fairness: a requester that re-requests immediately after its DELIVER is served only after every other pending requester.
- Reset mid-operation: all jobs are dropped and no req_done is emitted. The multiplier is reset by its own resetN; the arbiter does not wait for mul_flag.
- The error flags clear only on reset.

Test Plan:
- Single request: req_start[0] pulse with x=54'h1, y=48'h2; the multiplier model returns 54'h2 after 6 cycles.
  - Expect mul_start at T+2, mul_x=54'h1, mul_y=48'h2.
  - Expect req_done=3'b001 one cycle after mul_flag, req_res=54'h2.
- Simultaneous requests: req_start=3'b111 in one cycle.
  - Expect service order 0,1,2 and three distinct one-hot done pulses, each with the matching result.
- Fairness: requester 0 re-pulses in its DELIVER cycle while 1 and 2 are pending.
  - Expect order 0,1,2,0.
  - Expect requester 0's new operands captured, with no protocol_err.
- Duplicate start: a second req_start[1] with different operands while pending[1]=1.
  - Expect protocol_err=1 and the original operands sent to the multiplier.
- Timeout: TIMEOUT_CYC=8 and the multiplier model never asserts mul_flag.
  - Expect timeout_err=1, req_done for the granted requester, req_res=0, and the next pending request served.
- Reset mid-WAIT: drive resetN=0 for one cycle.
  - Expect IDLE, busy=0, no req_done.
  - A subsequent request completes normally.

Source files
------------

// File: rtl/gf26_mul_array_arbiter_if.sv
// Bundle of requester-side and multiplier-side signals for the GF(2^6) multiplier arbiter.
// The slave modport is the arbiter's view; the master modport drives requests and the multiplier response.
interface gf26_mul_array_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    req_start;
    logic [NUM_REQ*54-1:0] req_x;
    logic [NUM_REQ*48-1:0] req_y;
    logic [NUM_REQ-1:0]    req_done;
    logic [53:0]           req_res;
    logic                  busy;
    logic                  protocol_err;
    logic                  timeout_err;
    logic                  mul_start;
    logic [53:0]           mul_x;
    logic [47:0]           mul_y;
    logic                  mul_flag;
    logic [53:0]           mul_res;

    modport master (
        output req_start, req_x, req_y, mul_flag, mul_res,
        input  req_done, req_res, busy, protocol_err, timeout_err, mul_start, mul_x, mul_y
    );

    modport slave (
        input  req_start, req_x, req_y, mul_flag, mul_res,
        output req_done, req_res, busy, protocol_err, timeout_err, mul_start, mul_x, mul_y
    );
endinterface

// File: rtl/gf26_mul_array_arbiter.sv
// Round-robin arbiter sharing one gf26_mul_array between NUM_REQ decoder stages,
// with operand buffering, start/flag sequencing and a watchdog on the multiplier.
module gf26_mul_array_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int TIMEOUT_CYC = 255
) (
    input logic clk,
    input logic resetN,
    gf26_mul_array_arbiter_if.slave bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [GW-1:0]      LAST_INIT = GW'(NUM_REQ - 1);
    localparam logic [7:0]         TO_LAST   = 8'(TIMEOUT_CYC - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        DELIVER = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   pending_q, pending_d;
    logic [53:0]          buf_x_q [NUM_REQ];
    logic [53:0]          buf_x_d [NUM_REQ];
    logic [47:0]          buf_y_q [NUM_REQ];
    logic [47:0]          buf_y_d [NUM_REQ];
    logic [GW-1:0]        grant_q, grant_d;
    logic [GW-1:0]        last_grant_q, last_grant_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [NUM_REQ-1:0]   req_done_q, req_done_d;
    logic [53:0]          req_res_q, req_res_d;
    logic                 mul_start_q, mul_start_d;
    logic                 busy_q, busy_d;
    logic                 perr_q, perr_d;
    logic                 terr_q, terr_d;

    logic [GW-1:0]        rot_idx;
    logic [GW-1:0]        rr_pick;
    logic                 rr_hit;
    logic [NUM_REQ-1:0]   start_ok;

    // Round-robin pick: first pending index after last_grant (downward scan so the nearest wins).
    always_comb begin
        rot_idx = last_grant_q;
        rr_pick = last_grant_q;
        rr_hit  = |pending_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            rot_idx = GW'((int'(last_grant_q) + k) % NUM_REQ);
            rr_pick = pending_q[rot_idx] ? rot_idx : rr_pick;
        end
    end

    // Next-state, request capture and output computation.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        buf_x_d      = buf_x_q;
        buf_y_d      = buf_y_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        req_done_d   = {NUM_REQ{1'b0}};
        req_res_d    = req_res_q;
        mul_start_d  = 1'b0;
        perr_d       = perr_q;
        terr_d       = terr_q;
        start_ok     = {NUM_REQ{1'b0}};

        case (state_q)
            IDLE: begin
                if (rr_hit) begin
                    grant_d     = rr_pick;
                    mul_start_d = 1'b1;
                    state_d     = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                cnt_d   = 8'd0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.mul_flag) begin
                    req_res_d  = bus.mul_res;
                    req_done_d = ONE_HOT0 << grant_q;
                    state_d    = DELIVER;
                end else if (cnt_q == TO_LAST) begin
                    terr_d     = 1'b1;
                    req_res_d  = 54'd0;
                    req_done_d = ONE_HOT0 << grant_q;
                    state_d    = DELIVER;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DELIVER: begin
                pending_d[grant_q] = 1'b0;
                last_grant_d       = grant_q;
                state_d            = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Capture is applied after the DELIVER clear so a same-cycle restart is kept.
        for (int i = 0; i < NUM_REQ; i++) begin
            start_ok[i]  = bus.req_start[i] &
                           (~pending_q[i] | ((state_q == DELIVER) && (grant_q == GW'(i))));
            pending_d[i] = pending_d[i] | start_ok[i];
            buf_x_d[i]   = start_ok[i] ? bus.req_x[i*54 +: 54] : buf_x_d[i];
            buf_y_d[i]   = start_ok[i] ? bus.req_y[i*48 +: 48] : buf_y_d[i];
            perr_d       = perr_d | (bus.req_start[i] & ~start_ok[i]);
        end

        busy_d = (|pending_d) || (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q      <= IDLE;
            pending_q    <= {NUM_REQ{1'b0}};
            grant_q      <= {GW{1'b0}};
            last_grant_q <= LAST_INIT;
            cnt_q        <= 8'd0;
            req_done_q   <= {NUM_REQ{1'b0}};
            req_res_q    <= 54'd0;
            mul_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            perr_q       <= 1'b0;
            terr_q       <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                buf_x_q[i] <= 54'd0;
                buf_y_q[i] <= 48'd0;
            end
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            req_done_q   <= req_done_d;
            req_res_q    <= req_res_d;
            mul_start_q  <= mul_start_d;
            busy_q       <= busy_d;
            perr_q       <= perr_d;
            terr_q       <= terr_d;
            buf_x_q      <= buf_x_d;
            buf_y_q      <= buf_y_d;
        end
    end

    assign bus.req_done     = req_done_q;
    assign bus.req_res      = req_res_q;
    assign bus.busy         = busy_q;
    assign bus.protocol_err = perr_q;
    assign bus.timeout_err  = terr_q;
    assign bus.mul_start    = mul_start_q;
    assign bus.mul_x        = buf_x_q[grant_q];
    assign bus.mul_y        = buf_y_q[grant_q];
endmodule

// File: tb/tb_gf26_mul_array_arbiter.sv
// Scoreboard bench: captured requests are queued, a monitor predicts each grant round-robin
// from the queue and checks operands, done pulses, results, latency, busy and error flags.
module tb_gf26_mul_array_arbiter;
    localparam int N   = 3;
    localparam int TO  = 8;
    localparam int BIG = 32'h7fff_ffff;

    typedef struct {
        int          idx;
        int          cyc;
        logic [53:0] x;
        logic [47:0] y;
    } job_t;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    always #5 clk = ~clk;

    gf26_mul_array_arbiter_if #(.NUM_REQ(N)) bus ();
    gf26_mul_array_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    int   n_vec = 0, n_err = 0, cyc = 0;
    bit   mon_en = 1'b0;
    job_t sb_q[$];
    int   order_q[$];
    int   last_grant_m = N - 1, perr_from = BIG;
    bit   terr_m = 1'b0;
    bit   active = 1'b0;
    int   job_idx = 0, job_start = 0, last_start_cyc = -1;
    logic [53:0] job_x;
    logic [47:0] job_y;
    bit   job_hung = 1'b0, hang_next = 1'b0;
    int   job_lat = 0, fixed_lat = 0;
    int   n_done = 0, last_done_cyc = -1, last_done_idx = -1;

    function automatic logic [5:0] gf6_mul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] p, aa;
        p  = 6'd0;
        aa = a;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[4:0], 1'b0} ^ (aa[5] ? 6'h03 : 6'h00);
        end
        return p;
    endfunction

    // Stand-in multiplier: lanes 0..7 multiplied in GF(2^6), lane 8 of x passed through.
    function automatic logic [53:0] gf_ref(input logic [53:0] x, input logic [47:0] y);
        logic [53:0] r;
        r[53:48] = x[53:48];
        for (int k = 0; k < 8; k++) r[k*6 +: 6] = gf6_mul(x[k*6 +: 6], y[k*6 +: 6]);
        return r;
    endfunction

    function automatic logic [53:0] rnd54();
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        return v[53:0];
    endfunction

    function automatic int find_req(input int i, input int max_cyc);
        foreach (sb_q[k]) if (sb_q[k].idx == i && sb_q[k].cyc <= max_cyc) return k;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic set_ops(input int i, input logic [53:0] x, input logic [47:0] y);
        bus.req_x[i*54 +: 54] = x;
        bus.req_y[i*48 +: 48] = y;
    endtask

    // Drives one cycle of start pulses at the current negedge and updates the scoreboard.
    task automatic pulse(input logic [N-1:0] mask);
        bus.req_start = mask;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) begin
                if (find_req(i, BIG) >= 0) begin
                    if (cyc + 1 < perr_from) perr_from = cyc + 1;
                end else begin
                    sb_q.push_back('{i, cyc, bus.req_x[i*54 +: 54], bus.req_y[i*48 +: 48]});
                end
            end
        end
        @(negedge clk);
        bus.req_start = '0;
    endtask

    task automatic wait_dones(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (n_done < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, n_done, target);
    endtask

    task automatic do_reset();
        resetN    = 1'b0;
        sb_q.delete();
        last_grant_m = N - 1;
        perr_from = BIG;
        terr_m    = 1'b0;
        active    = 1'b0;
        hang_next = 1'b0;
        fixed_lat = 0;
        @(negedge clk);
        resetN = 1'b1;
    endtask

    // Multiplier model: flag pulse L cycles after mul_start, or never when a hang is armed.
    initial begin
        int          mcnt;
        logic [53:0] mx;
        logic [47:0] my;
        mcnt = 0;
        bus.mul_flag = 1'b0;
        bus.mul_res  = 54'd0;
        forever begin
            @(posedge clk);
            #2;
            bus.mul_res = rnd54();
            if (!resetN) begin
                mcnt = 0;
                bus.mul_flag = 1'b0;
            end else if (bus.mul_start) begin
                job_hung  = hang_next;
                hang_next = 1'b0;
                mcnt = job_hung ? -1 : ((fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 6)));
                job_lat = mcnt;
                mx = bus.mul_x;
                my = bus.mul_y;
                bus.mul_flag = 1'b0;
            end else if (mcnt > 0) begin
                mcnt--;
                bus.mul_flag = (mcnt == 0);
                if (mcnt == 0) bus.mul_res = gf_ref(mx, my);
            end else begin
                bus.mul_flag = 1'b0;
            end
        end
    end

    // Monitor: predicts grants at mul_start, checks done pulses against the scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (mon_en) begin
                bit exp_busy;
                exp_busy = 1'b0;
                foreach (sb_q[k]) if (sb_q[k].cyc <= cyc - 1) exp_busy = 1'b1;
                chk("busy", bus.busy, exp_busy);

                if (bus.mul_start) begin
                    int pick;
                    pick = -1;
                    chk("start_overlap", active, 0);
                    for (int k = 1; k <= N && pick < 0; k++)
                        if (find_req((last_grant_m + k) % N, cyc - 2) >= 0) pick = (last_grant_m + k) % N;
                    if (pick < 0) begin
                        chk("start_unexpected", bus.mul_start, 0);
                    end else begin
                        int e;
                        e = find_req(pick, cyc - 2);
                        chk("mul_x", bus.mul_x, sb_q[e].x);
                        chk("mul_y", bus.mul_y, sb_q[e].y);
                        job_x = sb_q[e].x;
                        job_y = sb_q[e].y;
                        job_idx = pick;
                        job_start = cyc;
                        last_start_cyc = cyc;
                        active = 1'b1;
                    end
                end

                if (bus.req_done != '0) begin
                    if (!active) begin
                        chk("done_unexpected", bus.req_done, 0);
                    end else begin
                        int e;
                        chk("done_onehot", bus.req_done, 64'd1 << job_idx);
                        if (job_hung) terr_m = 1'b1;
                        chk("result", bus.req_res, job_hung ? 54'd0 : gf_ref(job_x, job_y));
                        if (!job_hung) chk("latency", cyc - job_start, job_lat + 1);
                        e = find_req(job_idx, BIG);
                        if (e >= 0) sb_q.delete(e);
                        last_grant_m = job_idx;
                        active = 1'b0;
                        n_done++;
                        order_q.push_back(job_idx);
                        last_done_cyc = cyc;
                        last_done_idx = job_idx;
                    end
                end

                chk("protocol_err", bus.protocol_err, cyc >= perr_from);
                chk("timeout_err", bus.timeout_err, terr_m);
            end
        end
    end

    initial begin
        int t0, base, k;
        bus.req_start = '0;
        bus.req_x = '0;
        bus.req_y = '0;
        resetN = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_done", bus.req_done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_perr", bus.protocol_err, 0);
        chk("rst_terr", bus.timeout_err, 0);
        chk("rst_res", bus.req_res, 0);
        chk("rst_start", bus.mul_start, 0);
        chk("rst_mul_x", bus.mul_x, 0);
        resetN = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        // Single request, fixed 6-cycle multiplier.
        fixed_lat = 6;
        set_ops(0, 54'h1, 48'h2);
        t0 = cyc;
        pulse(3'b001);
        wait_dones(1, 40, "single_done");
        chk("single_start_cyc", last_start_cyc, t0 + 2);
        chk("single_res", bus.req_res, 54'h2);
        chk("single_order", order_q[0], 0);
        fixed_lat = 0;

        // Simultaneous requests from a fresh reset.
        do_reset();
        @(negedge clk);
        base = n_done;
        for (int i = 0; i < N; i++) set_ops(i, rnd54(), 48'(rnd54()));
        pulse(3'b111);
        wait_dones(base + 3, 80, "simul_done");
        for (int i = 0; i < 3; i++) chk("simul_order", order_q[base + i], i);

        // Fairness: requester 0 restarts in its own DELIVER cycle.
        base = n_done;
        for (int i = 0; i < N; i++) set_ops(i, rnd54(), 48'(rnd54()));
        pulse(3'b111);
        k = 0;
        while (!(last_done_cyc == cyc && last_done_idx == 0 && n_done == base + 1) && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("fair_deliver0_seen", n_done, base + 1);
        set_ops(0, rnd54(), 48'(rnd54()));
        pulse(3'b001);
        wait_dones(base + 4, 100, "fair_done");
        chk("fair_order0", order_q[base], 0);
        chk("fair_order1", order_q[base + 1], 1);
        chk("fair_order2", order_q[base + 2], 2);
        chk("fair_order3", order_q[base + 3], 0);
        chk("fair_no_perr", bus.protocol_err, 0);

        // Duplicate start while pending keeps the original operands.
        base = n_done;
        set_ops(1, 54'h0a5a5a5a5a5a5, 48'h123456789abc);
        pulse(3'b010);
        set_ops(1, 54'h3ffffffffffff, 48'hffffffffffff);
        pulse(3'b010);
        wait_dones(base + 1, 40, "dup_done");
        chk("dup_perr", bus.protocol_err, 1);

        // Timeout on a hung multiplier, then the next pending job proceeds.
        base = n_done;
        hang_next = 1'b1;
        set_ops(0, rnd54(), 48'(rnd54()));
        set_ops(1, rnd54(), 48'(rnd54()));
        pulse(3'b011);
        wait_dones(base + 2, 100, "timeout_done");
        chk("timeout_flag", bus.timeout_err, 1);
        chk("timeout_order0", order_q[base], 0);
        chk("timeout_order1", order_q[base + 1], 1);

        // Reset in the middle of WAIT.
        fixed_lat = 20;
        set_ops(2, rnd54(), 48'(rnd54()));
        pulse(3'b100);
        k = 0;
        while (!(active && cyc >= last_start_cyc + 2) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("reset_reached_wait", active, 1);
        do_reset();
        base = n_done;
        repeat (4) begin
            @(negedge clk);
            chk("rstw_busy", bus.busy, 0);
            chk("rstw_done", bus.req_done, 0);
            chk("rstw_start", bus.mul_start, 0);
        end
        chk("rstw_no_done", n_done, base);
        set_ops(1, rnd54(), 48'(rnd54()));
        pulse(3'b010);
        wait_dones(base + 1, 40, "rstw_after_done");

        // Random traffic with occasional hangs and duplicate starts.
        for (int c = 0; c < 300; c++) begin
            logic [N-1:0] m;
            for (int i = 0; i < N; i++) begin
                m[i] = ($urandom_range(0, 5) == 0);
                set_ops(i, rnd54(), 48'(rnd54()));
            end
            if ($urandom_range(0, 19) == 0) hang_next = 1'b1;
            pulse(m);
        end
        k = 0;
        while (sb_q.size() != 0 && k < 600) begin
            @(negedge clk);
            k++;
        end
        chk("drain", sb_q.size(), 0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
